// File: rtl/rom_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, the ROM read port and rom_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters/ROM side.
interface rom_arbiter_if;
  logic        flush_i;
  logic        m0_req_i;
  logic [31:0] m0_addr_i;
  logic        m0_gnt_o;
  logic        m0_rvalid_o;
  logic [31:0] m0_rdata_o;
  logic        m1_req_i;
  logic [31:0] m1_addr_i;
  logic        m1_gnt_o;
  logic        m1_rvalid_o;
  logic [31:0] m1_rdata_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;

  modport slave (
    input  flush_i, m0_req_i, m0_addr_i, m1_req_i, m1_addr_i, rom_data_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o, rom_addr_o
  );

  modport master (
    output flush_i, m0_req_i, m0_addr_i, m1_req_i, m1_addr_i, rom_data_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, rom_addr_o
  );
endinterface

// File: rtl/rom_arbiter.sv
// Two-master arbiter for the single combinational instruction-ROM read port (M0 fetch, M1 LSU).
// Define ROM_ARB_PERF_EN to add grant/conflict performance counters.
module rom_arbiter #(
  parameter int ARB_MODE   = 0,
  parameter int STARVE_MAX = 4
`ifdef ROM_ARB_PERF_EN
  , parameter int CNT_W    = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  rom_arbiter_if.slave     bus
`ifdef ROM_ARB_PERF_EN
  , output logic [CNT_W-1:0] m0_gnt_cnt_o
  , output logic [CNT_W-1:0] m1_gnt_cnt_o
  , output logic [CNT_W-1:0] conflict_cnt_o
`endif
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic        m0Elig, m1Elig;
  logic        gnt0, gnt1;
  logic [3:0]  starveCnt_q, starveCnt_d;
  logic        rrLast_q, rrLast_d;
  logic        m0Rvalid_q, m1Rvalid_q;
  logic [31:0] m0Rdata_q, m1Rdata_q;

  // A flushed fetch is not eligible, and nothing is granted while in reset.
  always_comb begin
    m0Elig = bus.m0_req_i & ~bus.flush_i & ~rst;
    m1Elig = bus.m1_req_i & ~rst;
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    if (m0Elig && m1Elig) begin
      if (ARB_MODE == 0) begin
        if (starveCnt_q == StarveMax) gnt1 = 1'b1;
        else                          gnt0 = 1'b1;
      end else begin
        if (rrLast_q) gnt0 = 1'b1;
        else          gnt1 = 1'b1;
      end
    end else begin
      gnt0 = m0Elig;
      gnt1 = m1Elig;
    end
  end

  // rrLast_q: 0 = M0 granted last, 1 = M1 granted last.
  always_comb begin
    starveCnt_d = 4'd0;
    if (bus.m1_req_i && !gnt1) begin
      starveCnt_d = (starveCnt_q == StarveMax) ? starveCnt_q : starveCnt_q + 4'd1;
    end
    rrLast_d = rrLast_q;
    if (gnt0)      rrLast_d = 1'b0;
    else if (gnt1) rrLast_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt_q <= 4'd0;
      rrLast_q    <= 1'b1;
      m0Rvalid_q  <= 1'b0;
      m1Rvalid_q  <= 1'b0;
      m0Rdata_q   <= 32'd0;
      m1Rdata_q   <= 32'd0;
    end else begin
      starveCnt_q <= starveCnt_d;
      rrLast_q    <= rrLast_d;
      m0Rvalid_q  <= gnt0;
      m1Rvalid_q  <= gnt1;
      if (gnt0) m0Rdata_q <= bus.rom_data_i;
      if (gnt1) m1Rdata_q <= bus.rom_data_i;
    end
  end

  // A flush arriving in the response cycle still kills the fetch response.
  assign bus.m0_gnt_o    = gnt0;
  assign bus.m1_gnt_o    = gnt1;
  assign bus.m0_rvalid_o = m0Rvalid_q & ~bus.flush_i;
  assign bus.m1_rvalid_o = m1Rvalid_q;
  assign bus.m0_rdata_o  = m0Rdata_q;
  assign bus.m1_rdata_o  = m1Rdata_q;
  assign bus.rom_addr_o  = gnt0 ? bus.m0_addr_i : (gnt1 ? bus.m1_addr_i : 32'd0);

`ifdef ROM_ARB_PERF_EN
  logic [CNT_W-1:0] m0GntCnt_q, m1GntCnt_q, conflictCnt_q;

  // Counters wrap naturally; conflicts count raw simultaneous requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0GntCnt_q    <= '0;
      m1GntCnt_q    <= '0;
      conflictCnt_q <= '0;
    end else begin
      if (gnt0) m0GntCnt_q <= m0GntCnt_q + 1'b1;
      if (gnt1) m1GntCnt_q <= m1GntCnt_q + 1'b1;
      if (bus.m0_req_i && bus.m1_req_i) conflictCnt_q <= conflictCnt_q + 1'b1;
    end
  end

  assign m0_gnt_cnt_o   = m0GntCnt_q;
  assign m1_gnt_cnt_o   = m1GntCnt_q;
  assign conflict_cnt_o = conflictCnt_q;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Testbench for rom_arbiter: a fixed-priority and a round-robin instance share one stimulus stream,
// with expected responses queued at grant time and compared one cycle later.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        m0Req = 1'b0, m1Req = 1'b0;
  logic [31:0] m0Addr = 32'd0, m1Addr = 32'd0;

  always #5 clk = ~clk;

  rom_arbiter_if bus0 ();
  rom_arbiter_if bus1 ();

  // ROM contents: word[2] is the known pattern, everything else is an address hash.
  function automatic logic [31:0] romWord(input logic [31:0] a);
    if (a[31:2] == 30'd2) return 32'hDEADBEEF;
    return {a[31:2], 2'b00} * 32'h9E3779B1 + 32'h13579BDF;
  endfunction

  assign bus0.flush_i = flush;  assign bus1.flush_i = flush;
  assign bus0.m0_req_i = m0Req; assign bus1.m0_req_i = m0Req;
  assign bus0.m1_req_i = m1Req; assign bus1.m1_req_i = m1Req;
  assign bus0.m0_addr_i = m0Addr; assign bus1.m0_addr_i = m0Addr;
  assign bus0.m1_addr_i = m1Addr; assign bus1.m1_addr_i = m1Addr;
  assign bus0.rom_data_i = romWord(bus0.rom_addr_o);
  assign bus1.rom_data_i = romWord(bus1.rom_addr_o);

`ifdef ROM_ARB_PERF_EN
  logic [31:0] pm0 [2], pm1 [2], pcf [2];
`endif

  rom_arbiter #(.ARB_MODE(0), .STARVE_MAX(4)
`ifdef ROM_ARB_PERF_EN
    , .CNT_W(32)
`endif
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
`ifdef ROM_ARB_PERF_EN
    , .m0_gnt_cnt_o(pm0[0]), .m1_gnt_cnt_o(pm1[0]), .conflict_cnt_o(pcf[0])
`endif
  );

  rom_arbiter #(.ARB_MODE(1), .STARVE_MAX(4)
`ifdef ROM_ARB_PERF_EN
    , .CNT_W(32)
`endif
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
`ifdef ROM_ARB_PERF_EN
    , .m0_gnt_cnt_o(pm0[1]), .m1_gnt_cnt_o(pm1[1]), .conflict_cnt_o(pcf[1])
`endif
  );

  logic        obsG0 [2], obsG1 [2], obsV0 [2], obsV1 [2];
  logic [31:0] obsA [2], obsD0 [2], obsD1 [2];
  assign obsG0[0] = bus0.m0_gnt_o;    assign obsG0[1] = bus1.m0_gnt_o;
  assign obsG1[0] = bus0.m1_gnt_o;    assign obsG1[1] = bus1.m1_gnt_o;
  assign obsV0[0] = bus0.m0_rvalid_o; assign obsV0[1] = bus1.m0_rvalid_o;
  assign obsV1[0] = bus0.m1_rvalid_o; assign obsV1[1] = bus1.m1_rvalid_o;
  assign obsA[0]  = bus0.rom_addr_o;  assign obsA[1]  = bus1.rom_addr_o;
  assign obsD0[0] = bus0.m0_rdata_o;  assign obsD0[1] = bus1.m0_rdata_o;
  assign obsD1[0] = bus0.m1_rdata_o;  assign obsD1[1] = bus1.m1_rdata_o;

  typedef struct packed {
    logic [1:0]       v0;
    logic [1:0]       v1;
    logic [1:0][31:0] data;
  } resp_t;

  resp_t       sbQ [$];
  int          checks = 0, errors = 0;
  int          starve [2];
  bit          rrLast [2];
  logic [31:0] lastD0 [2], lastD1 [2];
  bit          d0Known [2];
  int          obsM1Gnts [2];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference arbitration: instance 0 is fixed priority, instance 1 is round-robin.
  task automatic modelGrant(input int d, input bit e0, input bit e1, output bit g0, output bit g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (e0 && e1) begin
      if (d == 0) begin
        if (starve[d] == 4) g1 = 1'b1; else g0 = 1'b1;
      end else begin
        if (rrLast[d]) g0 = 1'b1; else g1 = 1'b1;
      end
    end else begin
      g0 = e0;
      g1 = e1;
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      starve[d]  = 0;
      rrLast[d]  = 1'b1;
      lastD0[d]  = 32'd0;
      lastD1[d]  = 32'd0;
      d0Known[d] = 1'b1;
    end
    sbQ.delete();
    sbQ.push_back('0);
  endtask

  // Called at posedge+1; checks responses and grants at the following negedge.
  task automatic applyStimulus(input bit r0, input logic [31:0] a0, input bit r1,
                               input logic [31:0] a1, input bit fl);
    resp_t exp, nxt;
    bit    g0, g1;
    m0Req = r0; m0Addr = a0; m1Req = r1; m1Addr = a1; flush = fl;
    @(negedge clk);
    exp = (sbQ.size() > 0) ? sbQ.pop_front() : resp_t'('0);
    nxt = '0;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("d%0d m0Rvalid", d), 32'(obsV0[d]), 32'(exp.v0[d] & ~fl));
      checkOutput($sformatf("d%0d m1Rvalid", d), 32'(obsV1[d]), 32'(exp.v1[d]));
      if (exp.v0[d]) begin
        lastD0[d]  = exp.data[d];
        d0Known[d] = !fl;
      end
      if (exp.v1[d]) lastD1[d] = exp.data[d];
      if (d0Known[d]) checkOutput($sformatf("d%0d m0Rdata", d), obsD0[d], lastD0[d]);
      checkOutput($sformatf("d%0d m1Rdata", d), obsD1[d], lastD1[d]);

      modelGrant(d, r0 & ~fl, r1, g0, g1);
      checkOutput($sformatf("d%0d m0Gnt", d), 32'(obsG0[d]), 32'(g0));
      checkOutput($sformatf("d%0d m1Gnt", d), 32'(obsG1[d]), 32'(g1));
      checkOutput($sformatf("d%0d romAddr", d), obsA[d], g0 ? a0 : (g1 ? a1 : 32'd0));
      if (obsG1[d] === 1'b1) obsM1Gnts[d]++;

      nxt.v0[d]   = g0;
      nxt.v1[d]   = g1;
      nxt.data[d] = g0 ? romWord(a0) : (g1 ? romWord(a1) : 32'd0);
      if (r1 && !g1) starve[d] = (starve[d] == 4) ? 4 : starve[d] + 1;
      else           starve[d] = 0;
      if (g0)      rrLast[d] = 1'b0;
      else if (g1) rrLast[d] = 1'b1;
    end
    sbQ.push_back(nxt);
    @(posedge clk);
    #1;
  endtask

  // Reset asserted from posedge+1: rvalid must drop at once, grants stay low.
  task automatic doReset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("d%0d rstM0Rvalid", d), 32'(obsV0[d]), 32'd0);
      checkOutput($sformatf("d%0d rstM1Rvalid", d), 32'(obsV1[d]), 32'd0);
    end
    m0Req = 1'b1; m0Addr = 32'h8; m1Req = 1'b0; m1Addr = 32'h0; flush = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("d%0d rstM0Gnt", d), 32'(obsG0[d]), 32'd0);
      checkOutput($sformatf("d%0d rstM1Gnt", d), 32'(obsG1[d]), 32'd0);
      checkOutput($sformatf("d%0d rstRomAddr", d), obsA[d], 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    int before0, before1;
    obsM1Gnts[0] = 0;
    obsM1Gnts[1] = 0;
    @(posedge clk);
    #1;
    doReset();

    applyStimulus(1, 32'h8, 0, 32'h0, 0);
    checkOutput("singleRvalid", 32'(obsV0[0]), 32'd1);
    checkOutput("singleRdata", obsD0[0], 32'hDEADBEEF);
    checkOutput("singleM1Rvalid", 32'(obsV1[0]), 32'd0);
    applyStimulus(0, 32'h0, 0, 32'h0, 0);

    doReset();
    before0 = obsM1Gnts[0];
    before1 = obsM1Gnts[1];
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 32'h100 + 32'(4 * i), 1, 32'h200 + 32'(4 * i), 0);
    checkOutput("fixedM1Share", 32'(obsM1Gnts[0] - before0), 32'd2);
    checkOutput("rrM1Share", 32'(obsM1Gnts[1] - before1), 32'd5);
    applyStimulus(0, 32'h0, 0, 32'h0, 0);

    applyStimulus(1, 32'h40, 0, 32'h0, 0);
    applyStimulus(1, 32'h44, 1, 32'h80, 1);
    checkOutput("flushM1Rvalid", 32'(obsV1[1]), 32'd1);
    checkOutput("flushM1Rdata", obsD1[1], romWord(32'h80));
    applyStimulus(0, 32'h0, 0, 32'h0, 0);

    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                    ($urandom_range(0, 7) == 0));

    applyStimulus(1, 32'h10, 0, 32'h0, 0);
    checkOutput("preRstRvalid", 32'(obsV0[0]), 32'd1);
    doReset();
    applyStimulus(0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 32'h0, 1, 32'h14, 0);
    applyStimulus(0, 32'h0, 0, 32'h0, 0);

`ifdef ROM_ARB_PERF_EN
    doReset();
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 32'h300 + 32'(4 * i), 1, 32'h400 + 32'(4 * i), 0);
    checkOutput("perfRrM0", pm0[1], 32'd5);
    checkOutput("perfRrM1", pm1[1], 32'd5);
    checkOutput("perfRrConflict", pcf[1], 32'd10);
    checkOutput("perfFixedM0", pm0[0], 32'd8);
    checkOutput("perfFixedM1", pm1[0], 32'd2);
    checkOutput("perfFixedConflict", pcf[0], 32'd10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
